// File: rtl/syn_weight_writer_if.sv
// Bus bundle for syn_weight_writer: session control, weight stream and SRAM write port.
// master = weight producer / session controller, slave = the writer block.
interface syn_weight_writer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 9
);
  logic              wr_en;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_cnt;
  logic              w_valid;
  logic [4:0]        w_data;
  logic              w_ready;
  logic              flush;
  logic              mem_cen;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, start, base_addr, word_cnt, w_valid, w_data, flush,
    input  w_ready, mem_cen, mem_wen, mem_addr, mem_din, busy, done
  );

  modport slave (
    input  wr_en, start, base_addr, word_cnt, w_valid, w_data, flush,
    output w_ready, mem_cen, mem_wen, mem_addr, mem_din, busy, done
  );
endinterface

// File: rtl/syn_weight_writer.sv
// Synapse weight write-back: packs eight 4-bit weights per 32-bit word (first weight in
// [31:28]) and issues one single-cycle SRAM write per word. All outputs are registered.
// Optional build macro WEIGHT_SAT_EN: weights above 15 saturate to 15 instead of truncating.
module syn_weight_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 9
) (
  input logic              clk,
  input logic              rst,
  syn_weight_writer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPack, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       pack_q, pack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              last_q, last_d;

  logic              w_ready_q, w_ready_d;
  logic              mem_cen_q, mem_cen_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0]        w_nib;
  logic              xfer;

`ifdef WEIGHT_SAT_EN
  // Saturate out-of-range update results to the largest storable weight.
  assign w_nib = (bus.w_data > 5'd15) ? 4'hf : bus.w_data[3:0];
`else
  logic unused_w_msb;
  // Truncate: the MSB of the update result is dropped.
  assign unused_w_msb = bus.w_data[4];
  assign w_nib        = bus.w_data[3:0];
`endif

  assign xfer = bus.w_valid & w_ready_q;

  // Next-state: session control, nibble packing and address/word bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pack_d      = pack_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    last_d      = last_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d      = bus.base_addr;
          remaining_d = bus.word_cnt;
          last_d      = 1'b0;
          idx_d       = 3'd0;
          pack_d      = 32'd0;
          state_d     = (bus.word_cnt == '0) ? StDone : StPack;
        end
      end
      StPack: begin
        if (xfer) begin
          for (int i = 0; i < 8; i++) begin
            if (idx_q == 3'(i)) pack_d[31-4*i -: 4] = w_nib;
          end
          idx_d = idx_q + 3'd1;
        end
        // Unfilled slots are already zero, so flushing only needs to force the write.
        if (bus.flush && (xfer || idx_q != 3'd0)) begin
          state_d = StWrite;
          last_d  = 1'b1;
        end else if (bus.flush) begin
          state_d = StDone;
        end else if (xfer && idx_q == 3'd7) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d      = addr_q + ADDR_W'(1);
        remaining_d = remaining_q - CNT_W'(1);
        idx_d       = 3'd0;
        pack_d      = 32'd0;
        state_d     = (remaining_q == CNT_W'(1) || last_q) ? StDone : StPack;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so that every output comes straight from a flop.
  always_comb begin
    w_ready_d  = (state_d == StPack);
    mem_cen_d  = (state_d != StWrite);
    mem_wen_d  = (state_d != StWrite);
    mem_addr_d = (state_d == StWrite) ? addr_q : '0;
    mem_din_d  = (state_d == StWrite) ? pack_d : 32'd0;
    busy_d     = (state_d == StPack) || (state_d == StWrite);
    done_d     = (state_d == StDone);
  end

  // State and output registers; reset or dropped wr_en discards everything synchronously.
  always_ff @(posedge clk) begin
    if (!rst || !bus.wr_en) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      pack_q      <= 32'd0;
      addr_q      <= '0;
      remaining_q <= '0;
      last_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      mem_cen_q   <= 1'b1;
      mem_wen_q   <= 1'b1;
      mem_addr_q  <= '0;
      mem_din_q   <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pack_q      <= pack_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
      w_ready_q   <= w_ready_d;
      mem_cen_q   <= mem_cen_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.w_ready  = w_ready_q;
  assign bus.mem_cen  = mem_cen_q;
  assign bus.mem_wen  = mem_wen_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_syn_weight_writer.sv
// Self-checking bench for syn_weight_writer: scoreboard of expected SRAM writes,
// popped by a monitor on every write cycle, plus directed timing/reset checks.
module tb_syn_weight_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  syn_weight_writer_if bus_if ();

  syn_weight_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] din;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: count done pulses and check each SRAM write against the scoreboard.
  always @(negedge clk) begin
    if (bus_if.done) done_cnt <= done_cnt + 1;
    if (rst && !bus_if.mem_cen) begin
      check("wr_wen", {31'd0, bus_if.mem_wen}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", {24'd0, bus_if.mem_addr}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wr_addr", {24'd0, bus_if.mem_addr}, {24'd0, e.addr});
        check("wr_din", bus_if.mem_din, e.din);
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.din  = d;
    sb_q.push_back(e);
  endtask

  task automatic start_session(input logic [7:0] base, input logic [8:0] cnt);
    @(posedge clk);
    #1;
    bus_if.start     = 1'b1;
    bus_if.base_addr = base;
    bus_if.word_cnt  = cnt;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  task automatic send_weight(input logic [4:0] v);
    int n;
    n = 0;
    bus_if.w_valid = 1'b1;
    bus_if.w_data  = v;
    while (!bus_if.w_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("w_ready_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
    bus_if.w_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flush = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base;
    base = done_cnt;
    for (int i = 0; i < 100 && done_cnt == base; i++) begin
      @(negedge clk);
      #1;
    end
    check(tag, done_cnt - base, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, bus_if.w_ready}, 32'd0);
    check({tag, "_cen"}, {31'd0, bus_if.mem_cen}, 32'd1);
    check({tag, "_wen"}, {31'd0, bus_if.mem_wen}, 32'd1);
    check({tag, "_addr"}, {24'd0, bus_if.mem_addr}, 32'd0);
    check({tag, "_din"}, bus_if.mem_din, 32'd0);
    check({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus_if.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    logic seen;
    bus_if.wr_en     = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.base_addr = '0;
    bus_if.word_cnt  = '0;
    bus_if.w_valid   = 1'b0;
    bus_if.w_data    = '0;
    bus_if.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst          = 1'b1;
    bus_if.wr_en = 1'b1;

    // 1: one word, back-to-back weights, write/done timing
    start_session(8'h10, 9'd1);
    push_exp(8'h10, 32'h1234_5678);
    for (int i = 1; i <= 8; i++) send_weight(5'(i));
    check("t1_write_cycle", {31'd0, bus_if.mem_cen}, 32'd0);
    check("t1_ready_in_write", {31'd0, bus_if.w_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_pulse", {31'd0, bus_if.done}, 32'd1);
    check("t1_cen_after", {31'd0, bus_if.mem_cen}, 32'd1);
    @(posedge clk);
    #1;
    check("t1_done_low", {31'd0, bus_if.done}, 32'd0);
    check("t1_busy_low", {31'd0, bus_if.busy}, 32'd0);

    // 2: address wrap across two words
    start_session(8'hff, 9'd2);
    push_exp(8'hff, 32'haaaa_aaaa);
    push_exp(8'h00, 32'haaaa_aaaa);
    for (int i = 0; i < 16; i++) begin
      send_weight(5'ha);
      if (i == 7) begin
        check("t2_ready_in_write", {31'd0, bus_if.w_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("t2_ready_after_write", {31'd0, bus_if.w_ready}, 32'd1);
      end
    end
    wait_done("t2_done");

    // 3: flush of a partial word
    start_session(8'h20, 9'd1);
    push_exp(8'h20, 32'hfed0_0000);
    send_weight(5'hf);
    send_weight(5'he);
    send_weight(5'hd);
    pulse_flush();
    wait_done("t3_done");
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen = seen | bus_if.w_ready;
    end
    check("t3_no_ready", {31'd0, seen}, 32'd0);

    // 4: out-of-range weight
    start_session(8'h21, 9'd1);
`ifdef WEIGHT_SAT_EN
    push_exp(8'h21, 32'hf000_0000);
`else
    push_exp(8'h21, 32'h4000_0000);
`endif
    send_weight(5'd20);
    for (int i = 0; i < 7; i++) send_weight(5'd0);
    wait_done("t4_done");

    // 5: wr_en dropped mid word 2
    start_session(8'h30, 9'd2);
    push_exp(8'h30, 32'h3333_3333);
    for (int i = 0; i < 13; i++) send_weight(5'd3);
    dc = done_cnt;
    bus_if.wr_en = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("t5_abort");
    bus_if.wr_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - dc, 32'd0);

    // 6: gappy valid, stray start mid-session
    start_session(8'h40, 9'd1);
    push_exp(8'h40, 32'h1234_5678);
    for (int i = 1; i <= 8; i++) begin
      send_weight(5'(i));
      if (i % 2 == 1) begin
        @(posedge clk);
        #1;
      end
      if (i == 4) begin
        bus_if.start     = 1'b1;
        bus_if.base_addr = 8'h99;
        bus_if.word_cnt  = 9'd5;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
      end
    end
    wait_done("t6_done");
    @(posedge clk);
    #1;
    check("t6_idle_busy", {31'd0, bus_if.busy}, 32'd0);

    // Zero-word session and flush on an empty word: done without writes
    start_session(8'h50, 9'd0);
    wait_done("cnt0_done");
    start_session(8'h60, 9'd3);
    pulse_flush();
    wait_done("flush_empty_done");

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
